sseg_scan_ctrl: RTL
===================

// Module: sseg_scan_ctrl
// PURPOSE
//   Time-multiplexed scan controller for an N-digit seven-segment display.
//   Shares one hexto7segment decoder across all digits.
//   Sequences the digit index, drives the decoder nibble, and gates the decoded
//   segments onto one-hot anode slots, with a dark gap between slots.
//   Holds new display words in a shadow register and swaps them in only at
//   frame boundaries, so a frame never shows a mix of old and new digits.
// PARAMETERS
//   NUM_DIGITS    4   digits scanned per frame (>=2)
//   DIGIT_CYCLES  16  clock cycles per digit slot (>=GAP_CYCLES+1)
//   GAP_CYCLES    2   dark cycles at start of each slot (>=1); decoder settles here
// PORTS
//   clk         in   1             rising-edge clock
//   reset_n     in   1             asynchronous, active-low reset
//   enable      in   1             scan enable; low forces IDLE (active data kept)
//   load_valid  in   1             new display word offered
//   load_ready  out  1             shadow free; transfer when valid&&ready at posedge
//   load_data   in   4*NUM_DIGITS  digit k = load_data[4k+3:4k]; digit 0 is the LSB nibble
//   blank_mask  in   NUM_DIGITS    bit k=1: digit k's lit phase shows seg_out=0, anode still driven
//   nib_out     out  4             nibble to decoder input; combinational from idx/active word
//   seg_in      in   7             decoder output (combinational from nib_out)
//   seg_out     out  7             registered segments to display
//   an_out      out  NUM_DIGITS    registered one-hot anode, active high
//   frame_done  out  1             registered 1-cycle pulse after final slot of each frame
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - State IDLE; idx=0; cnt=0; active=0; shadow=0.
//     - pending=0; have_data=0.
//     - load_ready=1; seg_out=0; an_out=0; frame_done=0; nib_out=0.
//   Handshake:
//     - load_ready = ~pending.
//     - In IDLE, an accepted load writes active directly and sets have_data.
//     - In SCAN, an accepted load writes shadow and sets pending.
//     - load_valid with load_ready low is held off; the master keeps data stable.
//   FSM:
//     - IDLE -> SCAN when enable && have_data. Entry cycle has idx=0, cnt=0.
//       A load accepted in IDLE this cycle also counts as have_data.
//     - SCAN -> IDLE on any cycle with enable=0. Sets idx=0 and cnt=0.
//       Registered outputs go 0 on the next edge. Shadow and pending are kept.
//     - A pending shadow is applied on the next wrap after enable returns.
//   SCAN counters:
//     - cnt counts 0..DIGIT_CYCLES-1.
//     - At cnt=DIGIT_CYCLES-1: cnt wraps to 0 and idx increments.
//     - idx wraps NUM_DIGITS-1 -> 0.
//   Frame wrap edge (idx=NUM_DIGITS-1, cnt=DIGIT_CYCLES-1):
//     - If pending: active<=shadow, pending<=0.
//     - A load accepted on this same edge goes to shadow and applies at the next wrap.
//   nib_out = active[4*idx+:4] in SCAN, else 0.
//   Registered outputs (next-state, from current internal state):
//     lit  = SCAN && enable && cnt>=GAP_CYCLES
//     an_out     <= lit ? (1<<idx) : 0
//     seg_out    <= (lit && !blank_mask[idx]) ? seg_in : 0
//     frame_done <= SCAN && enable && wrap edge
//   Externally visible per slot (after the 1-cycle register lag):
//     - GAP_CYCLES dark cycles, then DIGIT_CYCLES-GAP_CYCLES lit cycles.
//     - Frame period = NUM_DIGITS*DIGIT_CYCLES.
//     - Never two anodes at once. Anodes change only across a dark cycle.
//   Counter widths: $clog2 of the range, min 1 bit. No arithmetic overflow is possible.
//   Reset mid-frame: all outputs zero immediately. A word in flight is lost.
// TESTING (NUM_DIGITS=4, DIGIT_CYCLES=8, GAP_CYCLES=2; decoder = hexto7segment)
//   1 Reset, enable=1, no load -> an_out=0, seg_out=0, load_ready=1 for 100 cycles.
//   2 Load 16'h1234 in IDLE -> an_out pattern per slot is 2 dark + 6 lit.
//     Digit slots carry 0001/4, 0010/3, 0100/2, 1000/1 (anode/digit).
//     seg_out = hexto7segment(digit) while lit; frame_done every 32 cycles.
//   3 Load 16'hABCD mid-frame -> load_ready drops next cycle.
//     The current frame still shows 1234. The next frame shows D,C,B,A.
//     load_ready=1 one cycle after the wrap.
//   4 Second load while pending -> stalled, ready=0. Accepted on the cycle after the wrap.
//     Shown one frame later.
//   5 blank_mask=4'b0100 -> digit 2 slot: an_out=0100, seg_out=0 throughout the lit phase.
//   6 enable=0 mid-slot -> outputs 0 next cycle.
//     enable=1 -> restart at digit 0 with a full gap.
//     reset_n pulse mid-lit -> outputs 0 asynchronously.

Source files
------------

// File: rtl/sseg_scan_ctrl_if.sv
// sseg_scan_ctrl_if: valid/ready load channel carrying one display word to the scan controller
//   load_valid  master->slave  new display word offered
//   load_ready  slave->master  shadow free; transfer on valid&&ready at posedge
//   load_data   master->slave  digit k in [4k+3:4k], digit 0 is the LSB nibble
interface sseg_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;
  modport master (output load_valid, load_data, input load_ready);
  modport slave (input load_valid, load_data, output load_ready);
endinterface

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed N-digit seven-segment scanner with a shared decoder and frame-aligned word swap
//   clk, reset_n  clock, async active-low reset
//   enable        scan enable; low drops to IDLE keeping the active word
//   ld            load channel (slave side of sseg_scan_ctrl_if)
//   blank_mask    per-digit blanking of the lit phase
//   nib_out       nibble to the external decoder; seg_in is its output
//   seg_out       registered segments; an_out registered one-hot anode
//   frame_done    registered pulse after the last slot of each frame
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  sseg_scan_ctrl_if.slave       ld,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [3:0]            nib_out,
  input  logic [6:0]            seg_in,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  frame_done
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = DIGIT_CYCLES > 1 ? $clog2(DIGIT_CYCLES) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP      = CW'(GAP_CYCLES);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t                r_state, w_state_nx;
  logic [IW-1:0]         r_idx, w_idx_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic [DW-1:0]         r_active, r_shadow, w_shifted;
  logic                  r_pending, r_have_data, r_frame_done;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  w_accept, w_slot_end, w_wrap, w_run, w_lit, w_in_idle;
  assign ld.load_ready = ~r_pending;
  assign w_accept      = ld.load_valid & ~r_pending;
  assign w_in_idle     = r_state == IDLE;
  assign w_run         = r_state == SCAN && enable;
  assign w_slot_end    = r_cnt == LAST_CNT;
  assign w_wrap        = w_slot_end && r_idx == LAST_IDX;
  // the first GAP cycles of every slot stay dark while the shared decoder settles on the new nibble
  assign w_lit         = w_run && r_cnt >= GAP;
  assign w_shifted     = r_active >> {r_idx, 2'b00};
  assign nib_out       = w_in_idle ? 4'd0 : w_shifted[3:0];
  assign seg_out       = r_seg;
  assign an_out        = r_an;
  assign frame_done    = r_frame_done;
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    if (w_in_idle) begin
      w_state_nx = (enable && (r_have_data || w_accept)) ? SCAN : IDLE;
    end else if (!enable) begin
      w_state_nx = IDLE;
      w_idx_nx   = '0;
      w_cnt_nx   = '0;
    end else begin
      w_cnt_nx = w_slot_end ? '0 : r_cnt + 1'b1;
      w_idx_nx = !w_slot_end ? r_idx : (r_idx == LAST_IDX ? '0 : r_idx + 1'b1);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_active     <= '0;
      r_shadow     <= '0;
      r_pending    <= 1'b0;
      r_have_data  <= 1'b0;
      r_seg        <= '0;
      r_an         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_idx       <= w_idx_nx;
      r_cnt       <= w_cnt_nx;
      r_have_data <= r_have_data | (w_in_idle & w_accept);
      // IDLE loads go straight to the display; SCAN loads wait in the shadow for a frame boundary
      if (w_in_idle && w_accept)
        r_active <= ld.load_data;
      else if (w_run && w_wrap && r_pending)
        r_active <= r_shadow;
      if (!w_in_idle && w_accept)
        r_shadow <= ld.load_data;
      r_pending    <= (!w_in_idle && w_accept) | (r_pending & ~(w_run & w_wrap));
      r_an         <= w_lit ? NUM_DIGITS'(1) << r_idx : '0;
      r_seg        <= (w_lit && !blank_mask[r_idx]) ? seg_in : '0;
      r_frame_done <= w_run && w_wrap;
    end
  end
endmodule
